// File: rtl/avalon_st_mux2.sv
// Packet-aware 2:1 Avalon-ST merge: round-robin arbitration, grant held across a packet, registered output stage.
// Optional: define AVALON_ST_MUX2_CHANNEL_EN to add aso_out0_channel (source index of the output beat).
module avalon_st_mux2 #(
    parameter int INPUT_WIDTH  = 32,
    parameter bit LOCK_PACKETS = 1'b1
) (
    input  logic                   clock_clk,
    input  logic                   reset_reset_n,

    input  logic [INPUT_WIDTH-1:0] asi_in0_data,
    input  logic                   asi_in0_valid,
    output logic                   asi_in0_ready,
    input  logic                   asi_in0_startofpacket,
    input  logic                   asi_in0_endofpacket,

    input  logic [INPUT_WIDTH-1:0] asi_in1_data,
    input  logic                   asi_in1_valid,
    output logic                   asi_in1_ready,
    input  logic                   asi_in1_startofpacket,
    input  logic                   asi_in1_endofpacket,

    output logic [INPUT_WIDTH-1:0] aso_out0_data,
    output logic                   aso_out0_valid,
    output logic                   aso_out0_startofpacket,
    output logic                   aso_out0_endofpacket,
`ifdef AVALON_ST_MUX2_CHANNEL_EN
    output logic                   aso_out0_channel,
`endif
    input  logic                   aso_out0_ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_e;

    state_e                   state_q;
    state_e                   state_d;
    logic                     last_grant_q;
    logic                     last_grant_d;

    logic                     grant_s;
    logic                     can_accept_s;
    logic                     sel_valid_s;
    logic                     sel_sop_s;
    logic                     sel_eop_s;
    logic [INPUT_WIDTH-1:0]   sel_data_s;
    logic                     accept_s;

    logic [INPUT_WIDTH-1:0]   data_q;
    logic [INPUT_WIDTH-1:0]   data_d;
    logic                     valid_q;
    logic                     valid_d;
    logic                     sop_q;
    logic                     sop_d;
    logic                     eop_q;
    logic                     eop_d;
`ifdef AVALON_ST_MUX2_CHANNEL_EN
    logic                     chan_q;
    logic                     chan_d;
`endif

    // The output stage can take a new beat when empty or when its current beat leaves this cycle.
    assign can_accept_s = ~valid_q | aso_out0_ready;

    // Arbitration state and round-robin pointer register.
    always_ff @(posedge clock_clk) begin
        if (!reset_reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Grant decision; with no valid input the grant still points at the next round-robin turn.
    always_comb begin
        grant_s = ~last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (asi_in0_valid && !asi_in1_valid) begin
                    grant_s = 1'b0;
                end else if (asi_in1_valid && !asi_in0_valid) begin
                    grant_s = 1'b1;
                end else begin
                    grant_s = ~last_grant_q;
                end
            end
            ST_LOCK0: grant_s = 1'b0;
            ST_LOCK1: grant_s = 1'b1;
            default:  grant_s = ~last_grant_q;
        endcase
    end

    assign asi_in0_ready = can_accept_s & ~grant_s;
    assign asi_in1_ready = can_accept_s &  grant_s;

    // Beat selection from the granted input.
    always_comb begin
        if (grant_s) begin
            sel_valid_s = asi_in1_valid;
            sel_data_s  = asi_in1_data;
            sel_sop_s   = asi_in1_startofpacket;
            sel_eop_s   = asi_in1_endofpacket;
        end else begin
            sel_valid_s = asi_in0_valid;
            sel_data_s  = asi_in0_data;
            sel_sop_s   = asi_in0_startofpacket;
            sel_eop_s   = asi_in0_endofpacket;
        end
    end

    assign accept_s = sel_valid_s & can_accept_s;

    // Next state: lock on a non-eop beat accepted in IDLE, release only on an accepted eop.
    // A sop arriving mid-packet is deliberately ignored so the lock survives malformed streams.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && LOCK_PACKETS && !sel_eop_s) begin
                    state_d = grant_s ? ST_LOCK1 : ST_LOCK0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK0, ST_LOCK1: begin
                if (accept_s && sel_eop_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept_s && (sel_eop_s || !LOCK_PACKETS)) begin
            last_grant_d = grant_s;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Output stage next value: load on acceptance, drain when downstream takes the beat, else hold.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
`ifdef AVALON_ST_MUX2_CHANNEL_EN
        chan_d  = chan_q;
`endif
        if (accept_s) begin
            data_d  = sel_data_s;
            valid_d = 1'b1;
            sop_d   = sel_sop_s;
            eop_d   = sel_eop_s;
`ifdef AVALON_ST_MUX2_CHANNEL_EN
            chan_d  = grant_s;
`endif
        end else if (aso_out0_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output stage register; a reset discards any beat in flight.
    always_ff @(posedge clock_clk) begin
        if (!reset_reset_n) begin
            data_q  <= {INPUT_WIDTH{1'b0}};
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
`ifdef AVALON_ST_MUX2_CHANNEL_EN
            chan_q  <= 1'b0;
`endif
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
`ifdef AVALON_ST_MUX2_CHANNEL_EN
            chan_q  <= chan_d;
`endif
        end
    end

    assign aso_out0_data          = data_q;
    assign aso_out0_valid         = valid_q;
    assign aso_out0_startofpacket = sop_q;
    assign aso_out0_endofpacket   = eop_q;
`ifdef AVALON_ST_MUX2_CHANNEL_EN
    assign aso_out0_channel       = chan_q;
`endif

endmodule

// File: tb/tb_avalon_st_mux2.sv
// Bench for avalon_st_mux2: one packet-locked and one per-beat instance, directed scenarios then random traffic.
// Expected behaviour comes from a transaction-level arbitration model; build with AVALON_ST_MUX2_CHANNEL_EN to cover the channel port.
module tb_avalon_st_mux2;
    localparam int W = 32;
`ifdef AVALON_ST_MUX2_CHANNEL_EN
    localparam bit CH_EN = 1'b1;
`else
    localparam bit CH_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] d;
        logic         s;
        logic         e;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstn;
    // Input index = instance*2 + source; instance 0 locks packets, instance 1 arbitrates per beat.
    logic [W-1:0] in_d [4];
    logic         in_v [4];
    logic         in_s [4];
    logic         in_e [4];
    logic         in_r [4];
    logic         ordy [2];
    logic [W-1:0] od   [2];
    logic         ov   [2];
    logic         osop [2];
    logic         oeop [2];
    logic         och  [2];

    avalon_st_mux2 #(.INPUT_WIDTH(W), .LOCK_PACKETS(1'b1)) u_lock (
        .clock_clk(clk), .reset_reset_n(rstn),
        .asi_in0_data(in_d[0]), .asi_in0_valid(in_v[0]), .asi_in0_ready(in_r[0]),
        .asi_in0_startofpacket(in_s[0]), .asi_in0_endofpacket(in_e[0]),
        .asi_in1_data(in_d[1]), .asi_in1_valid(in_v[1]), .asi_in1_ready(in_r[1]),
        .asi_in1_startofpacket(in_s[1]), .asi_in1_endofpacket(in_e[1]),
        .aso_out0_data(od[0]), .aso_out0_valid(ov[0]),
        .aso_out0_startofpacket(osop[0]), .aso_out0_endofpacket(oeop[0]),
`ifdef AVALON_ST_MUX2_CHANNEL_EN
        .aso_out0_channel(och[0]),
`endif
        .aso_out0_ready(ordy[0])
    );

    avalon_st_mux2 #(.INPUT_WIDTH(W), .LOCK_PACKETS(1'b0)) u_beat (
        .clock_clk(clk), .reset_reset_n(rstn),
        .asi_in0_data(in_d[2]), .asi_in0_valid(in_v[2]), .asi_in0_ready(in_r[2]),
        .asi_in0_startofpacket(in_s[2]), .asi_in0_endofpacket(in_e[2]),
        .asi_in1_data(in_d[3]), .asi_in1_valid(in_v[3]), .asi_in1_ready(in_r[3]),
        .asi_in1_startofpacket(in_s[3]), .asi_in1_endofpacket(in_e[3]),
        .aso_out0_data(od[1]), .aso_out0_valid(ov[1]),
        .aso_out0_startofpacket(osop[1]), .aso_out0_endofpacket(oeop[1]),
`ifdef AVALON_ST_MUX2_CHANNEL_EN
        .aso_out0_channel(och[1]),
`endif
        .aso_out0_ready(ordy[1])
    );

`ifndef AVALON_ST_MUX2_CHANNEL_EN
    assign och[0] = 1'b0;
    assign och[1] = 1'b0;
`endif

    // Source queues feeding each input
    beat_t mem  [4][16];
    int    head [4];
    int    tail [4];
    logic  gate [4];

    // Reference model: which source owns the merge (-1 = nobody), whose turn was last, and the output beat.
    int           m_owner [2];
    int           m_last  [2];
    logic         m_ov    [2];
    logic         m_os    [2];
    logic         m_oe    [2];
    logic         m_oc    [2];
    logic [W-1:0] m_od    [2];

    // Log of beats leaving each instance: {channel, sop, eop, data} and cycle of departure.
    logic [W+2:0] log_b   [2][64];
    int           log_cyc [2][64];
    int           log_n   [2];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int idx, input logic [W-1:0] d, input logic s, input logic e);
        mem[idx][tail[idx]] = {d, s, e};
        tail[idx]++;
    endtask

    task automatic push_pkt(input int idx, input logic [W-1:0] base, input int len, input bit no_sop);
        for (int i = 0; i < len; i++) begin
            push(idx, base + W'(i), (i == 0) && !no_sop, i == len - 1);
        end
    endtask

    task automatic clear_queues();
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
    endtask

    function automatic bit all_empty();
        bit r = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (head[i] != tail[i]) r = 1'b0;
        end
        return r;
    endfunction

    // Round robin with packet ownership, from the arbitration rules.
    function automatic int m_grant(input int k);
        if (m_owner[k] >= 0) return m_owner[k];
        if (in_v[2*k] && !in_v[2*k+1]) return 0;
        if (in_v[2*k+1] && !in_v[2*k]) return 1;
        return 1 - m_last[k];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_last[k]  = 1;
            m_ov[k] = 1'b0; m_os[k] = 1'b0; m_oe[k] = 1'b0; m_oc[k] = 1'b0;
            m_od[k] = '0;
        end
    endtask

    // One clock: drive inputs, check readies, advance model at the edge, check outputs on the falling edge.
    task automatic step();
        int   g   [2];
        logic acc [2];
        logic can;
        int   src;
        for (int i = 0; i < 4; i++) begin
            if (head[i] != tail[i] && gate[i]) begin
                in_v[i] = 1'b1;
                in_d[i] = mem[i][head[i]].d;
                in_s[i] = mem[i][head[i]].s;
                in_e[i] = mem[i][head[i]].e;
            end else begin
                in_v[i] = 1'b0;
                in_d[i] = $urandom;
                in_s[i] = 1'($urandom_range(0, 1));
                in_e[i] = 1'($urandom_range(0, 1));
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            g[k]   = m_grant(k);
            can    = !m_ov[k] || ordy[k];
            acc[k] = rstn && can && in_v[2*k+g[k]];
            if (rstn) begin
                chk($sformatf("ready%0d", k), {62'd0, in_r[2*k], in_r[2*k+1]},
                    {62'd0, can && (g[k] == 0), can && (g[k] == 1)});
                if (ov[k] && ordy[k] && log_n[k] < 64) begin
                    log_b[k][log_n[k]]   = {och[k], osop[k], oeop[k], od[k]};
                    log_cyc[k][log_n[k]] = cyc;
                    log_n[k]++;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (rstn && in_v[i] && in_r[i]) head[i]++;
            if (head[i] == tail[i]) begin
                head[i] = 0;
                tail[i] = 0;
            end
        end
        @(posedge clk);
        cyc++;
        if (!rstn) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (acc[k]) begin
                    src     = 2*k + g[k];
                    m_ov[k] = 1'b1;
                    m_od[k] = in_d[src];
                    m_os[k] = in_s[src];
                    m_oe[k] = in_e[src];
                    m_oc[k] = CH_EN ? 1'(g[k]) : 1'b0;
                    if (m_owner[k] < 0) begin
                        if (k == 0 && !in_e[src]) m_owner[k] = g[k];
                    end else if (in_e[src]) begin
                        m_owner[k] = -1;
                    end
                    if (in_e[src] || k == 1) m_last[k] = g[k];
                end else if (ordy[k]) begin
                    m_ov[k] = 1'b0;
                end
            end
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("out%0d", k), {28'd0, och[k], ov[k], osop[k], oeop[k], od[k]},
                {28'd0, m_oc[k], m_ov[k], m_os[k], m_oe[k], m_od[k]});
        end
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int n = 0;
        while (!all_empty() && n < max_cycles) begin
            step();
            n++;
        end
        chk(tag, {63'd0, all_empty()}, 64'd1);
        for (int i = 0; i < 3; i++) step();
    endtask

    initial begin
        logic [W+1:0] exp_b;
        rstn = 1'b0;
        ordy[0] = 1'b1;
        ordy[1] = 1'b1;
        clear_queues();
        model_reset();
        for (int i = 0; i < 4; i++) gate[i] = 1'b1;
        log_n[0] = 0;
        log_n[1] = 0;

        // 1: reset with both inputs valid, then in0 wins first
        push(0, 32'h0000_0011, 1'b1, 1'b1);
        push(1, 32'h0000_0022, 1'b1, 1'b1);
        step();
        step();
        chk("reset_out", {31'd0, ov[0], osop[0], oeop[0], od[0]}, 64'd0);
        rstn = 1'b1;
        drain("t1_drain", 20);
        chk("t1_first", {32'd0, log_b[0][0][W-1:0]}, 64'h11);
        chk("t1_second", {32'd0, log_b[0][1][W-1:0]}, 64'h22);

        // 2: 4-beat packet on in0, in1 joins a cycle later and must wait for the eop
        log_n[0] = 0;
        push_pkt(0, 32'h0000_00A0, 4, 1'b0);
        push_pkt(1, 32'h0000_00B0, 2, 1'b0);
        gate[1] = 1'b0;
        step();
        gate[1] = 1'b1;
        drain("t2_drain", 30);
        chk("t2_count", 64'(log_n[0]), 64'd6);
        for (int i = 0; i < 6; i++) begin
            exp_b = (i < 4) ? {i == 0, i == 3, 32'hA0 + 32'(i)}
                            : {i == 4, i == 5, 32'hB0 + 32'(i - 4)};
            chk($sformatf("t2_beat%0d", i), {30'd0, log_b[0][i][W+1:0]}, {30'd0, exp_b});
        end
        chk("t2_contig", 64'(log_cyc[0][5] - log_cyc[0][0]), 64'd5);

        // 3: single-beat packets on both inputs alternate at full rate
        log_n[0] = 0;
        for (int i = 0; i < 8; i++) begin
            push(0, 32'hC0 + 32'(i), 1'b1, 1'b1);
            push(1, 32'hD0 + 32'(i), 1'b1, 1'b1);
        end
        drain("t3_drain", 40);
        chk("t3_count", 64'(log_n[0]), 64'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t3_beat%0d", i), {32'd0, log_b[0][i][W-1:0]},
                {32'd0, ((i % 2) == 0) ? 32'hC0 + 32'(i / 2) : 32'hD0 + 32'(i / 2)});
        end
        chk("t3_rate", 64'(log_cyc[0][15] - log_cyc[0][0]), 64'd15);

        // 4: downstream stall mid-packet holds the beat and loses nothing
        log_n[0] = 0;
        push_pkt(0, 32'h0000_0040, 5, 1'b0);
        push_pkt(1, 32'h0000_0050, 2, 1'b0);
        step();
        step();
        ordy[0] = 1'b0;
        step();
        step();
        step();
        ordy[0] = 1'b1;
        drain("t4_drain", 30);
        chk("t4_count", 64'(log_n[0]), 64'd7);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("t4_beat%0d", i), {32'd0, log_b[0][i][W-1:0]},
                {32'd0, (i < 5) ? 32'h40 + 32'(i) : 32'h50 + 32'(i - 5)});
        end

        // 5: per-beat arbitration interleaves two 3-beat packets
        log_n[1] = 0;
        push_pkt(2, 32'h0000_00E0, 3, 1'b0);
        push_pkt(3, 32'h0000_00F0, 3, 1'b0);
        drain("t5_drain", 20);
        chk("t5_count", 64'(log_n[1]), 64'd6);
        for (int i = 0; i < 6; i++) begin
            exp_b = ((i % 2) == 0) ? {i == 0, i == 4, 32'hE0 + 32'(i / 2)}
                                   : {i == 1, i == 5, 32'hF0 + 32'(i / 2)};
            chk($sformatf("t5_beat%0d", i), {30'd0, log_b[1][i][W+1:0]}, {30'd0, exp_b});
        end

        // 6: reset while locked to in1, then in0 is served first
        log_n[0] = 0;
        push_pkt(1, 32'h0000_0060, 4, 1'b0);
        step();
        step();
        clear_queues();
        push(0, 32'h0000_0070, 1'b1, 1'b1);
        rstn = 1'b0;
        step();
        chk("t6_discard", {63'd0, ov[0]}, 64'd0);
        rstn = 1'b1;
        push(1, 32'h0000_0071, 1'b1, 1'b1);
        log_n[0] = 0;
        drain("t6_drain", 20);
        chk("t6_count", 64'(log_n[0]), 64'd2);
        chk("t6_first", {29'd0, log_b[0][0]}, {29'd0, 1'b0, 1'b1, 1'b1, 32'h70});
        chk("t6_second", {29'd0, log_b[0][1]}, {29'd0, CH_EN, 1'b1, 1'b1, 32'h71});

        // Random traffic on both instances, including packets missing their sop
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (head[i] == tail[i]) begin
                    push_pkt(i, $urandom, int'($urandom_range(1, 4)), $urandom_range(0, 7) == 0);
                end
                gate[i] = ($urandom_range(0, 3) != 0);
            end
            ordy[0] = ($urandom_range(0, 9) < 7);
            ordy[1] = ($urandom_range(0, 9) < 7);
            step();
        end
        for (int i = 0; i < 4; i++) gate[i] = 1'b1;
        ordy[0] = 1'b1;
        ordy[1] = 1'b1;
        drain("rand_drain", 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
